// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared constants for the sequential divider family.
// Holds the FSM state encodings, the default operand width and the counter width helper.
package seq_div_pkg;

   // Default operand width: 24-bit mantissa significands.
   localparam int unsigned DEF_W = 24;

   // Step counter width for a given operand width.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

   localparam int unsigned CNT_W = cnt_width(DEF_W);

   // FSM state encodings.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/seq_div24_div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
module div_step
   import seq_div_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic [W:0]   r,
   input  logic         q_msb,
   input  logic [W-1:0] d,
   output logic [W:0]   r_next,
   output logic         q_bit
);

   // Compare at full width so r[W] is honoured; it stays 0 while r < d holds.
   always_comb begin
      q_bit  = ({r, q_msb} >= {2'b00, d});
      r_next = q_bit ? ({r[W-1:0], q_msb} - {1'b0, d}) : {r[W-1:0], q_msb};
   end

endmodule

// File: rtl/seq_div24.sv
// seq_div24: sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro SEQ_DIV_STICKY_EN adds a 'sticky' output (remainder != 0) for rounding.
// Results, done and sticky all update on the same edge, so outputs hold until the next done.
module seq_div24
   import seq_div_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
`ifdef SEQ_DIV_STICKY_EN
   output logic         sticky,
`endif
   output logic         div_by_zero
);

   localparam int unsigned   CW   = cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [1:0]    state;
   logic [CW-1:0] count;
   logic [W-1:0]  q_reg;
   logic [W-1:0]  d_reg;
   logic [W:0]    r_reg;
   logic [W:0]    r_next;
   logic          q_bit;
   logic          zero_reg;

   div_step #(
      .W(W)
   ) u_step (
      .r      (r_reg),
      .q_msb  (q_reg[W-1]),
      .d      (d_reg),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   // Busy covers the whole operation including the result-register cycle.
   assign busy = (state != ST_IDLE);

   // Control FSM, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         r_reg       <= '0;
         zero_reg    <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIV_STICKY_EN
         sticky      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  d_reg <= divisor;
                  count <= '0;
                  if (divisor != '0) begin
                     q_reg    <= dividend;
                     r_reg    <= '0;
                     zero_reg <= 1'b0;
                     state    <= ST_RUN;
                  end else begin
                     // Divide by zero skips iteration and reports saturated results.
                     q_reg    <= '1;
                     r_reg    <= {1'b0, dividend};
                     zero_reg <= 1'b1;
                     state    <= ST_FIN;
                  end
               end
            end
            ST_RUN: begin
               r_reg <= r_next;
               q_reg <= {q_reg[W-2:0], q_bit};
               count <= count + 1'b1;
               if (count == LAST) begin
                  state <= ST_FIN;
               end
            end
            ST_FIN: begin
               done        <= 1'b1;
               quotient    <= q_reg;
               remainder   <= r_reg[W-1:0];
               div_by_zero <= zero_reg;
`ifdef SEQ_DIV_STICKY_EN
               sticky      <= (r_reg[W-1:0] != '0);
`endif
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div24.sv
// tb_seq_div24: self-checking bench for seq_div24 with a behavioural divide model.
// Honours SEQ_DIV_STICKY_EN when the design is built with it.
module tb_seq_div24;

   localparam int W = 24;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
`ifdef SEQ_DIV_STICKY_EN
   logic         sticky;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   seq_div24 #(
      .W(W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
`ifdef SEQ_DIV_STICKY_EN
      .sticky      (sticky),
`endif
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one operation pending at a time, result appears after its latency.
   bit           m_pend = 1'b0;
   int           m_left = 0;
   logic [W-1:0] m_pq, m_pr, m_pa, m_pd;
   bit           m_pz;
   bit           e_done = 1'b0;
   logic [W-1:0] e_q = '0, e_r = '0, e_a = '0, e_d = '0;
   bit           e_dbz = 1'b0, e_sticky = 1'b0;
   int           n_acc = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_pend   = 1'b0;
         m_left   = 0;
         e_done   = 1'b0;
         e_q      = '0;
         e_r      = '0;
         e_dbz    = 1'b0;
         e_sticky = 1'b0;
      end else begin
         e_done = 1'b0;
         if (m_pend) begin
            m_left--;
            if (m_left == 0) begin
               m_pend   = 1'b0;
               e_done   = 1'b1;
               e_q      = m_pq;
               e_r      = m_pr;
               e_dbz    = m_pz;
               e_sticky = (m_pr != '0);
               e_a      = m_pa;
               e_d      = m_pd;
            end
         end else if (start) begin
            m_pend = 1'b1;
            m_pa   = dividend;
            m_pd   = divisor;
            n_acc++;
            if (divisor == '0) begin
               m_left = 1;
               m_pq   = '1;
               m_pr   = dividend;
               m_pz   = 1'b1;
            end else begin
               m_left = W + 1;
               m_pq   = dividend / divisor;
               m_pr   = dividend % divisor;
               m_pz   = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model, plus the arithmetic invariant.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_pend);
         check("done", done, e_done);
         check("quotient", quotient, e_q);
         check("remainder", remainder, e_r);
         check("div_by_zero", div_by_zero, e_dbz);
`ifdef SEQ_DIV_STICKY_EN
         check("sticky", sticky, e_sticky);
`endif
         if (e_done && !e_dbz) begin
            check("invariant", 64'(quotient) * 64'(e_d) + 64'(remainder), 64'(e_a));
            check("rem_lt_div", remainder < e_d, 1);
         end
      end
   end

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return W'(1);
         2:       return 24'hFFFFFF;
         3:       return 24'h800000;
         4:       return W'($urandom_range(0, 255));
         default: return W'($urandom);
      endcase
   endfunction

   task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] d);
      @(negedge clk);
      dividend = a;
      divisor  = d;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Called one negedge after the start edge; lat counts edges from the start edge to done.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat         = -1;
      busy_cycles = 0;
      for (int j = 0; j < 80; j++) begin
         if (done) begin
            lat = j;
            break;
         end
         if (busy) busy_cycles++;
         @(negedge clk);
      end
      check("done_seen", lat >= 0, 1);
   endtask

   initial begin
      int lat, bc, extra;

      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      rst = 1'b0;

      // 100 / 7
      pulse_start(24'd100, 24'd7);
      wait_done(lat, bc);
      check("lat_100_7", lat, 25);
      check("busy_100_7", bc, 25);
      check("q_100_7", quotient, 14);
      check("r_100_7", remainder, 2);
      check("dbz_100_7", div_by_zero, 0);

      // Back-to-back: 0xFFFFFF / 1 then 5 / 9
      pulse_start(24'hFFFFFF, 24'd1);
      wait_done(lat, bc);
      check("q_ffffff_1", quotient, 24'hFFFFFF);
      check("r_ffffff_1", remainder, 0);
      @(negedge clk);
      check("done_single", done, 0);
      dividend = 24'd5;
      divisor  = 24'd9;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done(lat, bc);
      check("lat_5_9", lat, 25);
      check("q_5_9", quotient, 0);
      check("r_5_9", remainder, 5);

      // Divide by zero
      pulse_start(24'h123456, 24'd0);
      wait_done(lat, bc);
      check("lat_dbz", lat, 1);
      check("q_dbz", quotient, 24'hFFFFFF);
      check("r_dbz", remainder, 24'h123456);
      check("dbz_flag", div_by_zero, 1);
`ifdef SEQ_DIV_STICKY_EN
      check("sticky_dbz", sticky, 1);
`endif

      // Start while busy is ignored
      pulse_start(24'd1000, 24'd3);
      repeat (8) @(negedge clk);
      dividend = 24'd50;
      divisor  = 24'd5;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done(lat, bc);
      check("q_1000_3", quotient, 333);
      check("r_1000_3", remainder, 1);
      check("dbz_1000_3", div_by_zero, 0);
`ifdef SEQ_DIV_STICKY_EN
      check("sticky_1000_3", sticky, 1);
`endif
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("ignored_start_no_done", extra, 0);

      // Reset mid-operation aborts it
      pulse_start(24'd1000, 24'd3);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_q", quotient, 0);
      check("abort_r", remainder, 0);
      check("abort_dbz", div_by_zero, 0);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("abort_no_done", extra, 0);
      pulse_start(24'd9, 24'd3);
      wait_done(lat, bc);
      check("q_9_3", quotient, 3);
      check("r_9_3", remainder, 0);
`ifdef SEQ_DIV_STICKY_EN
      check("sticky_9_3", sticky, 0);
`endif

      // Randomised sweep: operands change every cycle, rare resets
      for (int c = 0; c < 60000; c++) begin
         @(negedge clk);
         rst      = ($urandom_range(0, 2999) == 0);
         start    = ($urandom_range(0, 3) != 0);
         dividend = pick();
         divisor  = pick();
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (60) @(negedge clk);
      check("random_ops_accepted", n_acc > 1000, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
